sw_matrix_sched: RTL and testbench

Sequencing controller for the Smith-Waterman score-matrix fill. It walks a ROWS x COLS matrix in row-major order and, for each cell, presents the top, left and diagonal neighbour scores to the shared cell-score datapath (penalty adders plus the max unit). It captures the returned score and 2-bit source code, maintains the previous-row score buffer, writes source codes to traceback memory, and tracks the global maximum cell for the traceback stage.

---
 rtl/sw_matrix_sched_if.sv | 47 ++++
 rtl/sw_matrix_sched.sv | 182 ++++++++++++++++++
 tb/tb_sw_matrix_sched.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/sw_matrix_sched_if.sv
// Handshake and bus bundle between the Smith-Waterman fill scheduler and its
// environment (start/done control, cell-score datapath, traceback memory,
// best-cell report). The scheduler is the master side.
interface sw_matrix_sched_if #(
  parameter int SCORE_WIDTH_MAX = 7,
  parameter int ROWS            = 8,
  parameter int COLS            = 8
);
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int TB_AW = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1;

  logic                       start;
  logic                       busy;
  logic                       done;
  logic                       cell_req;
  logic [ROW_W-1:0]           cell_row;
  logic [COL_W-1:0]           cell_col;
  logic [SCORE_WIDTH_MAX-1:0] nbr_top;
  logic [SCORE_WIDTH_MAX-1:0] nbr_left;
  logic [SCORE_WIDTH_MAX-1:0] nbr_diag;
  logic                       cell_ack;
  logic [SCORE_WIDTH_MAX-1:0] cell_score;
  logic [1:0]                 cell_source;
  logic                       tb_we;
  logic [TB_AW-1:0]           tb_addr;
  logic [1:0]                 tb_data;
  logic [SCORE_WIDTH_MAX-1:0] best_score;
  logic [ROW_W-1:0]           best_row;
  logic [COL_W-1:0]           best_col;

  modport master (
    input  start, cell_ack, cell_score, cell_source,
    output busy, done, cell_req, cell_row, cell_col,
           nbr_top, nbr_left, nbr_diag,
           tb_we, tb_addr, tb_data,
           best_score, best_row, best_col
  );

  modport slave (
    output start, cell_ack, cell_score, cell_source,
    input  busy, done, cell_req, cell_row, cell_col,
           nbr_top, nbr_left, nbr_diag,
           tb_we, tb_addr, tb_data,
           best_score, best_row, best_col
  );
endinterface

// File: rtl/sw_matrix_sched.sv
// Smith-Waterman score-matrix fill sequencer. Walks the matrix row-major,
// presents top/left/diag neighbour scores for each cell, captures the result
// into a one-row score buffer, streams source codes to traceback memory and
// keeps the strictly-greatest (earliest on ties) cell as the best cell.
module sw_matrix_sched #(
  parameter int SCORE_WIDTH_MAX = 7,
  parameter int ROWS            = 8,
  parameter int COLS            = 8
) (
  input  logic               clk,
  input  logic               rst,
  sw_matrix_sched_if.master  bus
);
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int TB_AW = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1;
  localparam logic [SCORE_WIDTH_MAX-1:0] SCORE_ZERO = {SCORE_WIDTH_MAX{1'b0}};
  localparam logic [ROW_W-1:0]           ROW_ZERO   = {ROW_W{1'b0}};
  localparam logic [COL_W-1:0]           COL_ZERO   = {COL_W{1'b0}};
  localparam logic [ROW_W-1:0]           ROW_LAST   = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0]           COL_LAST   = COL_W'(COLS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                     state_q, state_d;
  logic [ROW_W-1:0]           row_q, row_d;
  logic [COL_W-1:0]           col_q, col_d;
  logic [SCORE_WIDTH_MAX-1:0] left_q, left_d;
  logic [SCORE_WIDTH_MAX-1:0] diag_q, diag_d;
  logic [SCORE_WIDTH_MAX-1:0] best_score_q, best_score_d;
  logic [ROW_W-1:0]           best_row_q, best_row_d;
  logic [COL_W-1:0]           best_col_q, best_col_d;
  logic [SCORE_WIDTH_MAX-1:0] rowbuf_q [COLS];

  logic start_s, accept_s, last_col_s, last_cell_s;
  logic busy_s, done_s, cell_req_s;

  assign start_s     = (state_q == ST_IDLE) && bus.start;
  assign accept_s    = (state_q == ST_FILL) && bus.cell_ack;
  assign last_col_s  = (col_q == COL_LAST);
  assign last_cell_s = last_col_s && (row_q == ROW_LAST);

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: start launches a fill, the last accept finishes it
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) state_d = ST_FILL;
        else           state_d = ST_IDLE;
      end
      ST_FILL: begin
        if (accept_s && last_cell_s) state_d = ST_DONE;
        else                         state_d = ST_FILL;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs decoded from the state register
  always_comb begin
    busy_s     = 1'b0;
    cell_req_s = 1'b0;
    done_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy_s     = 1'b0;
        cell_req_s = 1'b0;
        done_s     = 1'b0;
      end
      ST_FILL: begin
        busy_s     = 1'b1;
        cell_req_s = 1'b1;
      end
      ST_DONE: done_s = 1'b1;
      default: done_s = 1'b0;
    endcase
  end

  // Cell walk, neighbour registers and best-cell tracking next-state
  always_comb begin
    row_d        = row_q;
    col_d        = col_q;
    left_d       = left_q;
    diag_d       = diag_q;
    best_score_d = best_score_q;
    best_row_d   = best_row_q;
    best_col_d   = best_col_q;
    if (start_s) begin
      row_d        = ROW_ZERO;
      col_d        = COL_ZERO;
      left_d       = SCORE_ZERO;
      diag_d       = SCORE_ZERO;
      best_score_d = SCORE_ZERO;
      best_row_d   = ROW_ZERO;
      best_col_d   = COL_ZERO;
    end else if (accept_s) begin
      // Strictly greater keeps the earliest cell on ties and never moves on 0.
      if (bus.cell_score > best_score_q) begin
        best_score_d = bus.cell_score;
        best_row_d   = row_q;
        best_col_d   = col_q;
      end else begin
        best_score_d = best_score_q;
      end
      if (last_col_s) begin
        // New row: there is no left or diagonal neighbour at column 0.
        col_d  = COL_ZERO;
        left_d = SCORE_ZERO;
        diag_d = SCORE_ZERO;
        if (row_q == ROW_LAST) row_d = ROW_ZERO;
        else                   row_d = row_q + ROW_W'(1);
      end else begin
        col_d  = col_q + COL_W'(1);
        left_d = bus.cell_score;
        diag_d = rowbuf_q[col_q];
      end
    end else begin
      row_d = row_q;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q        <= ROW_ZERO;
      col_q        <= COL_ZERO;
      left_q       <= SCORE_ZERO;
      diag_q       <= SCORE_ZERO;
      best_score_q <= SCORE_ZERO;
      best_row_q   <= ROW_ZERO;
      best_col_q   <= COL_ZERO;
    end else begin
      row_q        <= row_d;
      col_q        <= col_d;
      left_q       <= left_d;
      diag_q       <= diag_d;
      best_score_q <= best_score_d;
      best_row_q   <= best_row_d;
      best_col_q   <= best_col_d;
    end
  end

  // Previous-row score buffer: cleared on start, one entry written per accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < COLS; i++) rowbuf_q[i] <= SCORE_ZERO;
    end else if (start_s) begin
      for (int i = 0; i < COLS; i++) rowbuf_q[i] <= SCORE_ZERO;
    end else if (accept_s) begin
      rowbuf_q[col_q] <= bus.cell_score;
    end
  end

  assign bus.busy       = busy_s;
  assign bus.done       = done_s;
  assign bus.cell_req   = cell_req_s;
  assign bus.cell_row   = row_q;
  assign bus.cell_col   = col_q;
  assign bus.nbr_top    = (cell_req_s && (row_q != ROW_ZERO)) ? rowbuf_q[col_q] : SCORE_ZERO;
  assign bus.nbr_left   = (cell_req_s && (col_q != COL_ZERO)) ? left_q : SCORE_ZERO;
  assign bus.nbr_diag   = (cell_req_s && (row_q != ROW_ZERO) && (col_q != COL_ZERO)) ? diag_q : SCORE_ZERO;
  assign bus.tb_we      = cell_req_s && bus.cell_ack;
  assign bus.tb_addr    = TB_AW'(row_q) * TB_AW'(COLS) + TB_AW'(col_q);
  assign bus.tb_data    = bus.cell_source;
  assign bus.best_score = best_score_q;
  assign bus.best_row   = best_row_q;
  assign bus.best_col   = best_col_q;
endmodule

// File: tb/tb_sw_matrix_sched.sv
// Self-checking bench for sw_matrix_sched on a 2x3 matrix: a cell-indexed
// reference model checked every cycle, plus hand-computed literal checks.
module tb_sw_matrix_sched;
  localparam int SW   = 7;
  localparam int ROWS = 2;
  localparam int COLS = 3;
  localparam int N    = ROWS * COLS;

  logic clk = 1'b0;
  logic rst = 1'b0;
  bit   chk_en = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  sw_matrix_sched_if #(.SCORE_WIDTH_MAX(SW), .ROWS(ROWS), .COLS(COLS)) bus ();
  sw_matrix_sched #(.SCORE_WIDTH_MAX(SW), .ROWS(ROWS), .COLS(COLS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference model: which cell is pending, scores accepted so far, best cell.
  bit m_active, m_done;
  int m_k, m_best, m_bestk;
  int m_grid [N];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= 1'b0; m_done <= 1'b0; m_k <= 0; m_best <= 0; m_bestk <= 0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (!m_active) begin
      if (bus.start) begin
        m_active <= 1'b1; m_k <= 0; m_best <= 0; m_bestk <= 0;
      end
    end else if (bus.cell_ack) begin
      m_grid[m_k] <= int'(bus.cell_score);
      if (int'(bus.cell_score) > m_best) begin
        m_best <= int'(bus.cell_score); m_bestk <= m_k;
      end
      if (m_k == N - 1) begin
        m_active <= 1'b0; m_done <= 1'b1;
      end else begin
        m_k <= m_k + 1;
      end
    end
  end

  // Per-cycle compare against the model
  int e_r, e_c, e_top, e_left, e_diag;
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", int'(bus.busy), int'(m_active));
      check("done", int'(bus.done), int'(m_done));
      check("cell_req", int'(bus.cell_req), int'(m_active));
      check("tb_we", int'(bus.tb_we), int'(m_active && bus.cell_ack));
      check("tb_data", int'(bus.tb_data), int'(bus.cell_source));
      check("best_score", int'(bus.best_score), m_best);
      check("best_row", int'(bus.best_row), m_bestk / COLS);
      check("best_col", int'(bus.best_col), m_bestk % COLS);
      if (m_active) begin
        e_r = m_k / COLS;
        e_c = m_k % COLS;
        e_top  = (e_r > 0) ? m_grid[m_k - COLS] : 0;
        e_left = (e_c > 0) ? m_grid[m_k - 1] : 0;
        e_diag = (e_r > 0 && e_c > 0) ? m_grid[m_k - COLS - 1] : 0;
        check("cell_row", int'(bus.cell_row), e_r);
        check("cell_col", int'(bus.cell_col), e_c);
        check("nbr_top", int'(bus.nbr_top), e_top);
        check("nbr_left", int'(bus.nbr_left), e_left);
        check("nbr_diag", int'(bus.nbr_diag), e_diag);
        check("tb_addr", int'(bus.tb_addr), m_k);
      end
    end
  end

  // Stimulus and observation for hand-computed checks
  int sc [N];
  int obs_top [N];
  int obs_left [N];
  int obs_diag [N];
  int done_cyc, done_cnt, we_cnt, held, we_stall;

  task automatic set_scores(input int a0, input int a1, input int a2,
                            input int a3, input int a4, input int a5);
    sc[0] = a0; sc[1] = a1; sc[2] = a2; sc[3] = a3; sc[4] = a4; sc[5] = a5;
  endtask

  // Called #1 after a posedge with the DUT idle. Cycle numbering: cycle 1 is
  // the one right after the edge that samples start.
  task automatic run_fill(input int stall_k, input int stall_n, input bit extra, input int rst_k);
    int cur, st, cyc;
    bit abort;
    cur = 0; st = 0; cyc = 1; abort = 1'b0;
    done_cyc = 0; done_cnt = 0; we_cnt = 0; held = 0; we_stall = 0;
    for (int i = 0; i < N; i++) begin
      obs_top[i] = -1; obs_left[i] = -1; obs_diag[i] = -1;
    end
    bus.start = 1'b1; bus.cell_ack = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    while (cyc < 60 && done_cyc == 0 && !abort) begin
      bus.start       = extra && (cyc == 2 || cyc == 3);
      bus.cell_score  = (cur < N) ? SW'(sc[cur]) : 7'd0;
      bus.cell_source = 2'(cur + 1);
      bus.cell_ack    = (cur < N) && !(cur == stall_k && st < stall_n);
      if (cur == rst_k) begin
        bus.cell_ack = 1'b1;
        rst = 1'b1;
        #1;
        check("rst_busy", int'(bus.busy), 0);
        check("rst_cell_req", int'(bus.cell_req), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_tb_we", int'(bus.tb_we), 0);
        check("rst_nbr_top", int'(bus.nbr_top), 0);
        check("rst_cell_row", int'(bus.cell_row), 0);
        check("rst_tb_addr", int'(bus.tb_addr), 0);
        check("rst_best_score", int'(bus.best_score), 0);
        abort = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
      end else begin
        @(negedge clk);
        if (bus.done) begin done_cyc = cyc; done_cnt++; end
        if (bus.tb_we) we_cnt++;
        if (bus.cell_req && st == 0 && cur < N) begin
          obs_top[cur] = int'(bus.nbr_top);
          obs_left[cur] = int'(bus.nbr_left);
          obs_diag[cur] = int'(bus.nbr_diag);
        end
        if (bus.cell_req && cur == stall_k) begin
          held++;
          if (bus.tb_we) we_stall++;
        end
        @(posedge clk); #1;
        if (bus.cell_ack) begin cur++; st = 0; end
        else st++;
        cyc++;
      end
    end
    bus.cell_ack = 1'b0; bus.start = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.cell_ack = 1'b0; bus.cell_score = 7'd0; bus.cell_source = 2'd0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_cell_req", int'(bus.cell_req), 0);
    check("reset_best_score", int'(bus.best_score), 0);
    check("reset_tb_addr", int'(bus.tb_addr), 0);
    @(posedge clk); #1;

    // Row wrap and neighbour selection, with stray starts in cycles 2 and 3
    set_scores(1, 2, 3, 2, 5, 1);
    run_fill(-1, 0, 1'b1, -1);
    check("wrap_top_1_0", obs_top[3], 1);
    check("wrap_left_1_0", obs_left[3], 0);
    check("wrap_diag_1_0", obs_diag[3], 0);
    check("top_1_2", obs_top[5], 3);
    check("diag_1_2", obs_diag[5], 2);
    check("left_1_2", obs_left[5], 5);
    check("best_score_a", int'(bus.best_score), 5);
    check("best_row_a", int'(bus.best_row), 1);
    check("best_col_a", int'(bus.best_col), 1);
    check("done_cycle_a", done_cyc, 7);
    check("done_count_a", done_cnt, 1);
    check("tb_writes_a", we_cnt, 6);

    // Two-cycle stall on cell (0,1)
    set_scores(3, 1, 2, 5, 4, 0);
    run_fill(1, 2, 1'b0, -1);
    check("stall_held", held, 3);
    check("stall_we", we_stall, 1);
    check("done_cycle_stall", done_cyc, 9);
    check("stall_top_1_1", obs_top[4], 1);
    check("stall_left_1_1", obs_left[4], 5);
    check("stall_diag_1_1", obs_diag[4], 3);
    check("best_score_b", int'(bus.best_score), 5);
    check("best_row_b", int'(bus.best_row), 1);
    check("best_col_b", int'(bus.best_col), 0);

    // Ties keep the earliest cell
    set_scores(4, 4, 2, 4, 1, 4);
    run_fill(-1, 0, 1'b0, -1);
    check("tie_best_score", int'(bus.best_score), 4);
    check("tie_best_row", int'(bus.best_row), 0);
    check("tie_best_col", int'(bus.best_col), 0);

    // All-zero matrix
    set_scores(0, 0, 0, 0, 0, 0);
    run_fill(-1, 0, 1'b0, -1);
    check("zero_best_score", int'(bus.best_score), 0);
    check("zero_best_row", int'(bus.best_row), 0);
    check("zero_best_col", int'(bus.best_col), 0);
    check("zero_done_cycle", done_cyc, 7);

    // Reset while cell (1,0) is presented: no done afterwards
    set_scores(9, 8, 7, 6, 5, 4);
    run_fill(-1, 0, 1'b0, 3);
    check("rst_no_done", done_cnt, 0);

    // Fresh fill after the abort, full-range scores
    set_scores(100, 127, 50, 60, 127, 70);
    run_fill(-1, 0, 1'b0, -1);
    check("fresh_top_0_0", obs_top[0], 0);
    check("fresh_top_1_0", obs_top[3], 100);
    check("fresh_diag_1_1", obs_diag[4], 100);
    check("fresh_best_score", int'(bus.best_score), 127);
    check("fresh_best_row", int'(bus.best_row), 0);
    check("fresh_best_col", int'(bus.best_col), 1);
    check("fresh_done_cycle", done_cyc, 7);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
